// File: rtl/cpu_debug_ocimem_arbiter.sv
// Arbiter sharing the single-port OCI debug RAM between the JTAG monitor path and the
// Avalon-MM debug slave, with a common access FSM and round-robin tie breaking.
module cpu_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_ld_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_done,
  output logic              jtag_err,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              ram_cs,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    J_ACC,
    J_RD,
    J_DONE,
    A_ACC,
    A_RD,
    A_DONE
  } state_t;

  typedef enum logic {
    GRANT_JTAG,
    GRANT_AVS
  } grant_t;

  state_t            state, state_nx;
  grant_t            last_grant, last_grant_nx;
  logic              jtag_pend;
  logic              jtag_wr_q;
  logic [DATA_W-1:0] jtag_wdata_q;
  logic [ADDR_W-1:0] jtag_ptr;

  logic jtag_busy;
  logic jtag_ld_ok;
  logic jtag_req_ok;
  logic jtag_want;
  logic avs_want;
  logic enter_j_acc;

  // The JTAG side is busy from the moment a strobe is pending until its J_DONE cycle ends.
  assign jtag_busy   = jtag_pend | (state inside {J_ACC, J_RD, J_DONE});
  assign jtag_ld_ok  = jtag_ld_addr & ~jtag_busy;
  assign jtag_req_ok = jtag_req & ~jtag_busy;
  // A fresh strobe competes in the same IDLE cycle so JTAG latency matches Avalon.
  assign jtag_want   = jtag_pend | jtag_req_ok;
  assign avs_want    = avs_read | avs_write;
  assign enter_j_acc = (state == IDLE) && (state_nx == J_ACC);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    unique case (state)
      IDLE: begin
        if (jtag_want && (!avs_want || last_grant == GRANT_AVS)) begin
          state_nx      = J_ACC;
          last_grant_nx = GRANT_JTAG;
        end else if (avs_want) begin
          state_nx      = A_ACC;
          last_grant_nx = GRANT_AVS;
        end
      end
      J_ACC:   state_nx = jtag_wr_q ? J_DONE : J_RD;
      J_RD:    state_nx = J_DONE;
      J_DONE:  state_nx = IDLE;
      A_ACC:   state_nx = (avs_read && !avs_write) ? A_RD : A_DONE;
      A_RD:    state_nx = A_DONE;
      A_DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values and simulation order between processes cannot matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= GRANT_AVS;
      jtag_pend    <= 1'b0;
      jtag_ptr     <= '0;
      jtag_err     <= 1'b0;
      jtag_rdata   <= '0;
      avs_readdata <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;

      // A load can never coincide with J_DONE, since J_DONE counts as busy.
      if (jtag_ld_ok) begin
        jtag_ptr <= jtag_addr;
      end else if (state == J_DONE) begin
        jtag_ptr <= jtag_ptr + ADDR_W'(1);
      end

      if (enter_j_acc) begin
        jtag_pend <= 1'b0;
      end else if (jtag_req_ok) begin
        jtag_pend <= 1'b1;
      end

      if ((jtag_req || jtag_ld_addr) && jtag_busy) begin
        jtag_err <= 1'b1;
      end else if (jtag_ld_ok) begin
        jtag_err <= 1'b0;
      end

      if (state == J_RD) jtag_rdata <= ram_rdata;
      if (state == A_RD) avs_readdata <= ram_rdata;
    end
  end

  // NOTE: the latched command is pure datapath qualified by jtag_pend, so it carries no reset.
  always_ff @(posedge clk) begin
    if (jtag_req_ok) begin
      jtag_wr_q    <= jtag_wr;
      jtag_wdata_q <= jtag_wdata;
    end
  end

  // RAM strobes are masked during reset so an abandoned access cannot write.
  always_comb begin
    ram_cs    = 1'b0;
    ram_wren  = 1'b0;
    ram_addr  = jtag_ptr;
    ram_wdata = jtag_wdata_q;
    if (!reset) begin
      case (state)
        J_ACC: begin
          ram_cs   = 1'b1;
          ram_wren = jtag_wr_q;
        end
        A_ACC: begin
          ram_cs    = 1'b1;
          ram_wren  = avs_write;
          ram_addr  = avs_address;
          ram_wdata = avs_writedata;
        end
        default: ;
      endcase
    end
  end

  assign jtag_done       = (state == J_DONE) && !reset;
  assign avs_waitrequest = avs_want && ((state != A_DONE) || reset);

endmodule

// File: tb/tb_cpu_debug_ocimem_arbiter.sv
// Scoreboard bench for cpu_debug_ocimem_arbiter: completions are popped from an ordered
// queue of expected results, with a behavioural single-port RAM on the RAM port.
module tb_cpu_debug_ocimem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          jtag_ld_addr;
  logic [AW-1:0] jtag_addr;
  logic          jtag_req;
  logic          jtag_wr;
  logic [DW-1:0] jtag_wdata;
  logic [DW-1:0] jtag_rdata;
  logic          jtag_done;
  logic          jtag_err;
  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [DW-1:0] avs_writedata;
  logic [DW-1:0] avs_readdata;
  logic          avs_waitrequest;
  logic          ram_cs;
  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  cpu_debug_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .jtag_ld_addr(jtag_ld_addr), .jtag_addr(jtag_addr), .jtag_req(jtag_req),
    .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata), .jtag_rdata(jtag_rdata),
    .jtag_done(jtag_done), .jtag_err(jtag_err),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_cs(ram_cs), .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural OCI RAM: synchronous write, read data one cycle after the select.
  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      else          ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    bit            side;  // 0 = JTAG, 1 = Avalon
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void push_exp(input bit side, input bit rd, input logic [DW-1:0] data);
    exp_t e;
    e.side = side;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endfunction

  // Completion monitor: each completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && jtag_done) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL jtag_done_unexpected: completion seen, required none outstanding");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.side != 1'b0)
          $display("FAIL completion_order: got JTAG, required Avalon");
        else if (mon_e.rd && jtag_rdata !== mon_e.data)
          $display("FAIL jtag_rdata: got %h, required %h", jtag_rdata, mon_e.data);
        else
          n_pass++;
      end
    end
    if (!reset && (avs_read || avs_write) && !avs_waitrequest) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL avs_done_unexpected: completion seen, required none outstanding");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.side != 1'b1)
          $display("FAIL completion_order: got Avalon, required JTAG");
        else if (mon_e.rd && avs_readdata !== mon_e.data)
          $display("FAIL avs_readdata: got %h, required %h", avs_readdata, mon_e.data);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_ld(input logic [AW-1:0] a);
    tick();
    jtag_ld_addr = 1'b1;
    jtag_addr    = a;
    tick();
    jtag_ld_addr = 1'b0;
  endtask

  // One JTAG strobe (optionally with a same-cycle pointer load); returns cycles to done.
  task automatic jtag_acc(input bit wr, input logic [DW-1:0] wdata, input bit ld,
                          input logic [AW-1:0] a, input logic [DW-1:0] exp_rd,
                          output int lat);
    int n;
    tick();
    jtag_req   = 1'b1;
    jtag_wr    = wr;
    jtag_wdata = wdata;
    if (ld) begin
      jtag_ld_addr = 1'b1;
      jtag_addr    = a;
    end
    push_exp(1'b0, !wr, exp_rd);
    tick();
    jtag_req     = 1'b0;
    jtag_ld_addr = 1'b0;
    n = 1;
    @(negedge clk);
    while (!jtag_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  // One Avalon transfer; returns the cycle index at which waitrequest dropped.
  task automatic avs_acc(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_rd, output int lat);
    int n;
    tick();
    avs_read      = !wr;
    avs_write     = wr;
    avs_address   = a;
    avs_writedata = d;
    push_exp(1'b1, !wr, exp_rd);
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  // JTAG read and Avalon read strobed in the same IDLE cycle.
  task automatic tie(input logic [AW-1:0] a, input logic [DW-1:0] j_exp,
                     input logic [DW-1:0] a_exp, input bit jtag_first,
                     output int jd, output int ad);
    int cyc;
    tick();
    jtag_req    = 1'b1;
    jtag_wr     = 1'b0;
    avs_read    = 1'b1;
    avs_address = a;
    if (jtag_first) begin
      push_exp(1'b0, 1'b1, j_exp);
      push_exp(1'b1, 1'b1, a_exp);
    end else begin
      push_exp(1'b1, 1'b1, a_exp);
      push_exp(1'b0, 1'b1, j_exp);
    end
    tick();
    jtag_req = 1'b0;
    jd = 0;
    ad = 0;
    cyc = 1;
    while ((jd == 0 || ad == 0) && cyc < 30) begin
      @(negedge clk);
      if (jtag_done) jd = cyc;
      if (avs_read && !avs_waitrequest) ad = cyc;
      tick();
      if (ad != 0) avs_read = 1'b0;
      cyc++;
    end
    avs_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks += 6;
    if (jtag_rdata !== '0)   $display("FAIL rst_jtag_rdata: got %h, required 0", jtag_rdata); else n_pass++;
    if (avs_readdata !== '0) $display("FAIL rst_avs_readdata: got %h, required 0", avs_readdata); else n_pass++;
    if (jtag_done !== 1'b0)  $display("FAIL rst_jtag_done: got %b, required 0", jtag_done); else n_pass++;
    if (jtag_err !== 1'b0)   $display("FAIL rst_jtag_err: got %b, required 0", jtag_err); else n_pass++;
    if (ram_cs !== 1'b0)     $display("FAIL rst_ram_cs: got %b, required 0", ram_cs); else n_pass++;
    if (ram_wren !== 1'b0)   $display("FAIL rst_ram_wren: got %b, required 0", ram_wren); else n_pass++;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (avs_waitrequest !== 1'b0) $display("FAIL idle_waitrequest: got %b, required 0", avs_waitrequest); else n_pass++;
    if (ram_cs !== 1'b0)          $display("FAIL idle_ram_cs: got %b, required 0", ram_cs); else n_pass++;
  endtask

  task automatic test_jtag_rw();
    int lat;
    jtag_ld(8'h10);
    jtag_acc(1'b1, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0, lat);
    n_checks += 2;
    if (lat != 2) $display("FAIL jtag_wr_latency: got %0d, required 2", lat); else n_pass++;
    if (mem[8'h10] !== 32'hDEADBEEF) $display("FAIL jtag_wr_ram: got %h, required deadbeef", mem[8'h10]); else n_pass++;
    // Load and read strobed together: the read must use the freshly loaded pointer.
    jtag_acc(1'b0, 32'h0, 1'b1, 8'h10, 32'hDEADBEEF, lat);
    n_checks++;
    if (lat != 3) $display("FAIL jtag_rd_latency: got %0d, required 3", lat); else n_pass++;
    @(negedge clk);
    n_checks += 2;
    if (jtag_done !== 1'b0) $display("FAIL jtag_done_width: got %b, required 0", jtag_done); else n_pass++;
    if (jtag_rdata !== 32'hDEADBEEF) $display("FAIL jtag_rdata_hold: got %h, required deadbeef", jtag_rdata); else n_pass++;
    jtag_acc(1'b1, 32'hA5A50011, 1'b0, 8'h00, 32'h0, lat);
    n_checks++;
    if (mem[8'h11] !== 32'hA5A50011) $display("FAIL jtag_ptr_incr: got %h, required a5a50011", mem[8'h11]); else n_pass++;
  endtask

  task automatic test_avs_rw();
    int lat;
    avs_acc(1'b1, 8'h05, 32'h1234, 32'h0, lat);
    n_checks += 2;
    if (lat != 2) $display("FAIL avs_wr_latency: got %0d, required 2", lat); else n_pass++;
    if (mem[8'h05] !== 32'h1234) $display("FAIL avs_wr_ram: got %h, required 1234", mem[8'h05]); else n_pass++;
    avs_acc(1'b0, 8'h05, 32'h0, 32'h1234, lat);
    n_checks++;
    if (lat != 3) $display("FAIL avs_rd_latency: got %0d, required 3", lat); else n_pass++;
  endtask

  task automatic test_round_robin();
    int jd, ad, lat;
    do_reset();
    jtag_ld(8'h10);
    tie(8'h05, 32'hDEADBEEF, 32'h1234, 1'b1, jd, ad);
    n_checks += 2;
    if (jd != 3) $display("FAIL rr1_jtag_cycle: got %0d, required 3", jd); else n_pass++;
    if (ad != 7) $display("FAIL rr1_avs_cycle: got %0d, required 7", ad); else n_pass++;
    // A solo JTAG grant makes JTAG the last winner, so the next tie goes to Avalon.
    jtag_acc(1'b1, 32'h11112222, 1'b0, 8'h00, 32'h0, lat);
    jtag_ld(8'h11);
    tie(8'h10, 32'h11112222, 32'hDEADBEEF, 1'b0, jd, ad);
    n_checks += 2;
    if (ad != 3) $display("FAIL rr2_avs_cycle: got %0d, required 3", ad); else n_pass++;
    if (jd != 7) $display("FAIL rr2_jtag_cycle: got %0d, required 7", jd); else n_pass++;
  endtask

  task automatic test_ptr_wrap();
    int lat;
    jtag_ld(8'hFF);
    jtag_acc(1'b1, 32'hFFFF0001, 1'b0, 8'h00, 32'h0, lat);
    jtag_acc(1'b1, 32'h00000002, 1'b0, 8'h00, 32'h0, lat);
    jtag_acc(1'b1, 32'h01010003, 1'b0, 8'h00, 32'h0, lat);
    n_checks += 3;
    if (mem[8'hFF] !== 32'hFFFF0001) $display("FAIL wrap_ff: got %h, required ffff0001", mem[8'hFF]); else n_pass++;
    if (mem[8'h00] !== 32'h00000002) $display("FAIL wrap_00: got %h, required 00000002", mem[8'h00]); else n_pass++;
    if (mem[8'h01] !== 32'h01010003) $display("FAIL wrap_01: got %h, required 01010003", mem[8'h01]); else n_pass++;
  endtask

  task automatic test_busy_drop();
    int lat;
    logic [DW-1:0] old21;
    jtag_ld(8'h20);
    jtag_acc(1'b1, 32'h55550020, 1'b0, 8'h00, 32'h0, lat);
    old21 = mem[8'h21];
    @(negedge clk);
    n_checks++;
    if (jtag_err !== 1'b0) $display("FAIL err_before_drop: got %b, required 0", jtag_err); else n_pass++;
    tick();
    jtag_ld_addr = 1'b1;
    jtag_addr    = 8'h20;
    jtag_req     = 1'b1;
    jtag_wr      = 1'b0;
    push_exp(1'b0, 1'b1, 32'h55550020);
    tick();
    jtag_ld_addr = 1'b0;
    jtag_req     = 1'b0;
    tick();
    jtag_req   = 1'b1;   // lands in J_RD: must be dropped
    jtag_wr    = 1'b1;
    jtag_wdata = 32'hBAD0BAD0;
    tick();
    jtag_req = 1'b0;
    jtag_wr  = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    n_checks += 3;
    if (jtag_err !== 1'b1) $display("FAIL err_set: got %b, required 1", jtag_err); else n_pass++;
    if (mem[8'h20] !== 32'h55550020) $display("FAIL drop_ram20: got %h, required 55550020", mem[8'h20]); else n_pass++;
    if (mem[8'h21] !== old21) $display("FAIL drop_ram21: got %h, required %h", mem[8'h21], old21); else n_pass++;
    jtag_ld(8'h30);
    @(negedge clk);
    n_checks++;
    if (jtag_err !== 1'b0) $display("FAIL err_clear: got %b, required 0", jtag_err); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int n;
    logic [DW-1:0] old06;
    old06 = mem[8'h06];
    tick();
    avs_write     = 1'b1;
    avs_address   = 8'h06;
    avs_writedata = 32'h00006666;
    tick();
    reset = 1'b1;        // FSM is in A_ACC this cycle
    @(negedge clk);
    n_checks += 3;
    if (ram_wren !== 1'b0) $display("FAIL rst_acc_wren: got %b, required 0", ram_wren); else n_pass++;
    if (ram_cs !== 1'b0)   $display("FAIL rst_acc_cs: got %b, required 0", ram_cs); else n_pass++;
    if (avs_waitrequest !== 1'b1) $display("FAIL rst_acc_wait: got %b, required 1", avs_waitrequest); else n_pass++;
    tick();
    reset = 1'b0;
    push_exp(1'b1, 1'b0, 32'h0);
    n = 0;
    @(negedge clk);
    n_checks += 2;
    if (avs_waitrequest !== 1'b1) $display("FAIL rst_after_wait: got %b, required 1", avs_waitrequest); else n_pass++;
    if (mem[8'h06] !== old06) $display("FAIL rst_no_write: got %h, required %h", mem[8'h06], old06); else n_pass++;
    while (avs_waitrequest && n < 20) begin
      @(negedge clk);
      n++;
    end
    tick();
    avs_write = 1'b0;
    n_checks += 2;
    if (n != 2) $display("FAIL rst_restart_latency: got %0d, required 2", n); else n_pass++;
    if (mem[8'h06] !== 32'h00006666) $display("FAIL rst_retry_write: got %h, required 00006666", mem[8'h06]); else n_pass++;
  endtask

  initial begin
    reset         = 1'b1;
    jtag_ld_addr  = 1'b0;
    jtag_addr     = '0;
    jtag_req      = 1'b0;
    jtag_wr       = 1'b0;
    jtag_wdata    = '0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    test_reset();
    test_jtag_rw();
    test_avs_rw();
    test_round_robin();
    test_ptr_wrap();
    test_busy_drop();
    test_reset_mid_write();

    repeat (4) tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
